// File: rtl/aabb_closest_hit_reducer.sv
`default_nettype none
// ============================================================================
// Module   : aabb_closest_hit_reducer
// Summary  : Streams one ray's hit candidates and keeps the nearest valid hit.
//            In any-hit mode, comparison stops at the first hit.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`ifndef NULL_PRIMITIVE_INDEX
`define NULL_PRIMITIVE_INDEX 16'hFFFF
`endif

module aabb_closest_hit_reducer #(
    parameter int CNT_WIDTH = 16,
    parameter int FIXED_W   = `FIXED_WIDTH,
    parameter int PI_W      = 16,
    parameter int COLOR_W   = 24,
    parameter int SURF_W    = 4,
    parameter int NORMAL_W  = 48,
    parameter logic [PI_W-1:0] NULL_PI = `NULL_PRIMITIVE_INDEX
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_hit_b_hit,
    input  logic [FIXED_W-1:0]   in_hit_t,
    input  logic [PI_W-1:0]      in_hit_pi,
    input  logic [COLOR_W-1:0]   in_hit_color,
    input  logic [SURF_W-1:0]    in_hit_surface_type,
    input  logic [NORMAL_W-1:0]  in_hit_normal,
    input  logic                 in_last,
    input  logic                 in_any_hit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_hit_b_hit,
    output logic [FIXED_W-1:0]   out_hit_t,
    output logic [PI_W-1:0]      out_hit_pi,
    output logic [COLOR_W-1:0]   out_hit_color,
    output logic [SURF_W-1:0]    out_hit_surface_type,
    output logic [NORMAL_W-1:0]  out_hit_normal,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]           state_q,   state_d;
    logic                 mode_q,    mode_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic                 b_hit_q,   b_hit_d;
    logic [FIXED_W-1:0]   t_q,       t_d;
    logic [PI_W-1:0]      pi_q,      pi_d;
    logic [COLOR_W-1:0]   color_q,   color_d;
    logic [SURF_W-1:0]    surf_q,    surf_d;
    logic [NORMAL_W-1:0]  normal_q,  normal_d;

    logic                 accept;
    logic                 take;
    logic [CNT_WIDTH-1:0] count_inc;

    assign in_ready  = (state_q != S_OUTPUT);
    assign out_valid = (state_q == S_OUTPUT);
    assign accept    = in_valid && in_ready;

    // Strict less-than: on equal T the earlier candidate is kept.
    assign take = in_hit_b_hit && (!b_hit_q || ($signed(in_hit_t) < $signed(t_q)));

    assign count_inc = (count_q == {CNT_WIDTH{1'b1}}) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        b_hit_d  = b_hit_q;
        t_d      = t_q;
        pi_d     = pi_q;
        color_d  = color_q;
        surf_d   = surf_q;
        normal_d = normal_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d  = in_any_hit;
                    count_d = CNT_WIDTH'(1);
                    if (in_hit_b_hit) begin
                        b_hit_d  = 1'b1;
                        t_d      = in_hit_t;
                        pi_d     = in_hit_pi;
                        color_d  = in_hit_color;
                        surf_d   = in_hit_surface_type;
                        normal_d = in_hit_normal;
                    end else begin
                        b_hit_d  = 1'b0;
                        t_d      = '0;
                        pi_d     = NULL_PI;
                        color_d  = '0;
                        surf_d   = '0;
                        normal_d = '0;
                    end
                    if (in_last)
                        state_d = S_OUTPUT;
                    else if (in_any_hit && in_hit_b_hit)
                        state_d = S_DRAIN;
                    else
                        state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    count_d = count_inc;
                    if (take) begin
                        b_hit_d  = 1'b1;
                        t_d      = in_hit_t;
                        pi_d     = in_hit_pi;
                        color_d  = in_hit_color;
                        surf_d   = in_hit_surface_type;
                        normal_d = in_hit_normal;
                    end
                    if (in_last)
                        state_d = S_OUTPUT;
                    else if (mode_q && in_hit_b_hit)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    count_d = count_inc;
                    if (in_last)
                        state_d = S_OUTPUT;
                end
            end
            default: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            count_q  <= '0;
            b_hit_q  <= 1'b0;
            t_q      <= '0;
            pi_q     <= NULL_PI;
            color_q  <= '0;
            surf_q   <= '0;
            normal_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            b_hit_q  <= b_hit_d;
            t_q      <= t_d;
            pi_q     <= pi_d;
            color_q  <= color_d;
            surf_q   <= surf_d;
            normal_q <= normal_d;
        end
    end

    assign out_hit_b_hit        = b_hit_q;
    assign out_hit_t            = t_q;
    assign out_hit_pi           = pi_q;
    assign out_hit_color        = color_q;
    assign out_hit_surface_type = surf_q;
    assign out_hit_normal       = normal_q;
    assign out_count            = count_q;

endmodule

`default_nettype wire

// File: tb/tb_aabb_closest_hit_reducer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aabb_closest_hit_reducer
// Summary  : Table-driven rays with a result scoreboard, plus backpressure,
//            reset and counter-saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aabb_closest_hit_reducer;

    localparam int ONE = 65536;   // Q16.16 fixed point
    localparam logic [15:0] NULL_PI = 16'hFFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic        in_hit_b_hit;
    logic [31:0] in_hit_t;
    logic [15:0] in_hit_pi;
    logic [23:0] in_hit_color;
    logic [3:0]  in_hit_surface_type;
    logic [47:0] in_hit_normal;
    logic        in_last, in_any_hit;
    logic        out_valid, out_ready;
    logic        out_hit_b_hit;
    logic [31:0] out_hit_t;
    logic [15:0] out_hit_pi;
    logic [23:0] out_hit_color;
    logic [3:0]  out_hit_surface_type;
    logic [47:0] out_hit_normal;
    logic [15:0] out_count;

    always #5 clk = ~clk;

    aabb_closest_hit_reducer dut (
        .clk                  (clk),
        .resetn               (resetn),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_hit_b_hit         (in_hit_b_hit),
        .in_hit_t             (in_hit_t),
        .in_hit_pi            (in_hit_pi),
        .in_hit_color         (in_hit_color),
        .in_hit_surface_type  (in_hit_surface_type),
        .in_hit_normal        (in_hit_normal),
        .in_last              (in_last),
        .in_any_hit           (in_any_hit),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_hit_b_hit        (out_hit_b_hit),
        .out_hit_t            (out_hit_t),
        .out_hit_pi           (out_hit_pi),
        .out_hit_color        (out_hit_color),
        .out_hit_surface_type (out_hit_surface_type),
        .out_hit_normal       (out_hit_normal),
        .out_count            (out_count)
    );

    typedef struct {
        logic        b_hit;
        logic [31:0] t;
        logic [15:0] pi;
        logic        last;
        logic        any;
        logic        exp_hit;
        logic [31:0] exp_t;
        logic [15:0] exp_pi;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [31:0] t;
        logic [15:0] pi;
        logic [15:0] cnt;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [75:0] payload(input logic hit, input logic [15:0] pi);
        if (hit)
            return {8'hA5, pi, pi[3:0], pi, pi, pi};
        return '0;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void add(input logic h, input int t, input int pi, input logic last,
                                input logic any, input logic eh, input int et,
                                input int epi, input int ecnt);
        vec_t v;
        v.b_hit = h; v.t = t; v.pi = pi[15:0]; v.last = last; v.any = any;
        v.exp_hit = eh; v.exp_t = et; v.exp_pi = epi[15:0]; v.exp_cnt = ecnt[15:0];
        vecs.push_back(v);
    endfunction

    task automatic push_exp(input logic h, input logic [31:0] t, input logic [15:0] pi,
                            input logic [15:0] cnt);
        res_t r;
        r.hit = h; r.t = t; r.pi = pi; r.cnt = cnt;
        sb.push_back(r);
    endtask

    task automatic scramble();
        in_hit_b_hit        = 1'($urandom);
        in_hit_t            = $urandom;
        in_hit_pi           = 16'($urandom);
        in_hit_color        = 24'($urandom);
        in_hit_surface_type = 4'($urandom);
        in_hit_normal       = {16'($urandom), 32'($urandom)};
        in_last             = 1'($urandom);
        in_any_hit          = 1'($urandom);
    endtask

    task automatic set_beat(input logic h, input logic [31:0] t, input logic [15:0] pi,
                            input logic last, input logic any);
        in_valid            = 1'b1;
        in_hit_b_hit        = h;
        in_hit_t            = t;
        in_hit_pi           = pi;
        in_hit_color        = {8'hA5, pi};
        in_hit_surface_type = pi[3:0];
        in_hit_normal       = {pi, pi, pi};
        in_last             = last;
        in_any_hit          = any;
    endtask

    // Holds the beat until it is accepted; returns #1 after the accepting edge.
    task automatic drive_beat(input logic h, input logic [31:0] t, input logic [15:0] pi,
                              input logic last, input logic any);
        logic acc;
        int   n;
        set_beat(h, t, pi, last, any);
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 20) begin
                check("accept_timeout", 96'd0, 96'd1);
                break;
            end
        end
        in_valid = 1'b0;
        scramble();
    endtask

    initial begin
        logic [31:0] held_t;
        int          wait_n;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scramble();

        // Table: closest, misses, any-hit, negative T, single beat, any-hit first-beat hit,
        // mode sampled only on the first beat.
        add(1,  5*ONE,  3, 0, 0, 0, 0, 0, 0);
        add(0,  1*ONE,  4, 0, 0, 0, 0, 0, 0);
        add(1,  2*ONE,  7, 0, 0, 0, 0, 0, 0);
        add(1,  2*ONE,  9, 1, 0, 1, 2*ONE, 7, 4);
        add(0,  1*ONE,  1, 0, 0, 0, 0, 0, 0);
        add(0, -2*ONE,  2, 0, 0, 0, 0, 0, 0);
        add(0,  0,      5, 1, 0, 0, 0, 16'hFFFF, 3);
        add(0,  4*ONE, 10, 0, 1, 0, 0, 0, 0);
        add(1,  6*ONE, 12, 0, 0, 0, 0, 0, 0);
        add(0,  1*ONE, 13, 0, 0, 0, 0, 0, 0);
        add(1,  1*ONE, 14, 0, 0, 0, 0, 0, 0);
        add(1,  ONE/2, 15, 1, 0, 1, 6*ONE, 12, 5);
        add(1, -1*ONE, 20, 0, 0, 0, 0, 0, 0);
        add(1,  3*ONE, 21, 1, 0, 1, -1*ONE, 20, 2);
        add(1,  7*ONE, 30, 1, 1, 1, 7*ONE, 30, 1);
        add(1,  9*ONE, 40, 0, 1, 0, 0, 0, 0);
        add(1,  1*ONE, 41, 0, 0, 0, 0, 0, 0);
        add(0,  0,     42, 1, 0, 1, 9*ONE, 40, 3);
        add(0,  1*ONE, 49, 0, 0, 0, 0, 0, 0);
        add(1,  5*ONE, 50, 0, 1, 0, 0, 0, 0);
        add(1,  2*ONE, 51, 1, 1, 1, 2*ONE, 51, 3);

        fork
            forever begin
                res_t r;
                @(negedge clk);
                if (resetn && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 96'd1, 96'd0);
                    end else begin
                        r = sb.pop_front();
                        check("out_b_hit",   96'(out_hit_b_hit), 96'(r.hit));
                        check("out_t",       96'(out_hit_t),     96'(r.t));
                        check("out_pi",      96'(out_hit_pi),    96'(r.pi));
                        check("out_count",   96'(out_count),     96'(r.cnt));
                        check("out_payload",
                              96'({out_hit_color, out_hit_surface_type, out_hit_normal}),
                              96'(payload(r.hit, r.pi)));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  96'(in_ready),      96'd1);
        check("rst_out_valid", 96'(out_valid),     96'd0);
        check("rst_out_count", 96'(out_count),     96'd0);
        check("rst_b_hit",     96'(out_hit_b_hit), 96'd0);
        check("rst_pi",        96'(out_hit_pi),    96'(NULL_PI));
        check("rst_t",         96'(out_hit_t),     96'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        foreach (vecs[i]) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            if (vecs[i].last)
                push_exp(vecs[i].exp_hit, vecs[i].exp_t, vecs[i].exp_pi, vecs[i].exp_cnt);
            drive_beat(vecs[i].b_hit, vecs[i].t, vecs[i].pi, vecs[i].last, vecs[i].any);
            check(vecs[i].last ? "latency_out_valid" : "early_out_valid",
                  96'(out_valid), 96'(vecs[i].last));
        end

        // Backpressure: result held while the next ray's beat waits.
        @(posedge clk);
        #1 out_ready = 1'b0;
        push_exp(1'b1, ONE + ONE/2, 16'd60, 16'd1);
        drive_beat(1'b1, ONE + ONE/2, 16'd60, 1'b1, 1'b0);
        push_exp(1'b1, 32'd8, 16'd61, 16'd1);
        set_beat(1'b1, 32'd8, 16'd61, 1'b1, 1'b0);
        held_t = ONE + ONE/2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_in_ready",  96'(in_ready),   96'd0);
            check("bp_out_valid", 96'(out_valid),  96'd1);
            check("bp_pi",        96'(out_hit_pi), 96'd60);
            check("bp_t",         96'(out_hit_t),  96'(held_t));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_in_ready",  96'(in_ready),  96'd1);
        check("bp_idle_out_valid", 96'(out_valid), 96'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        scramble();
        check("bp_next_latency", 96'(out_valid), 96'd1);
        @(posedge clk);
        #1;

        // Reset mid-ACCUM discards the partial ray.
        drive_beat(1'b1, 4*ONE, 16'd70, 1'b0, 1'b0);
        drive_beat(1'b1, 2*ONE, 16'd71, 1'b0, 1'b0);
        resetn = 1'b0;
        #2;
        check("midrst_out_valid", 96'(out_valid), 96'd0);
        check("midrst_in_ready",  96'(in_ready),  96'd1);
        check("midrst_count",     96'(out_count), 96'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        push_exp(1'b1, 9*ONE, 16'd72, 16'd1);
        drive_beat(1'b1, 9*ONE, 16'd72, 1'b1, 1'b0);

        // Counter saturation: 65537 misses report 65535.
        push_exp(1'b0, 32'd0, NULL_PI, 16'hFFFF);
        for (int k = 0; k < 65537; k++)
            drive_beat(1'b0, 32'd0, 16'd99, (k == 65536), 1'b0);

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        if (sb.size() != 0)
            check("scoreboard_drain", 96'(sb.size()), 96'd0);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
